// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receiver state encoding, frame geometry and
// default conditioning/timeout parameters.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DPS,
    LOAD
  } rx_state_t;

  localparam int unsigned PS2_FRAME_BITS = 11;
  localparam int unsigned PS2_DATA_BITS  = 8;

  localparam int unsigned FILTER_LEN_DEF = 8;
  localparam int unsigned TIMEOUT_DEF    = 5000;

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 line conditioning: 2-flop synchronizers, clock debounce filter and
// falling-edge tick on the filtered clock. Shared with ps2_transmitter.
module ps2_clk_filter
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN = FILTER_LEN_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_c_in,
  input  logic ps2_d_in,
  output logic fall_tick,
  output logic data_sync
);

  logic [1:0]            r_c_sync;
  logic [1:0]            r_d_sync;
  logic [FILTER_LEN-1:0] r_filter;
  logic                  r_fclk;
  logic                  w_fclk_next;

  // Idle PS/2 lines are pulled high, so everything resets to 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_c_sync <= '1;
      r_d_sync <= '1;
      r_filter <= '1;
      r_fclk   <= 1'b1;
    end else begin
      r_c_sync <= {r_c_sync[0], ps2_c_in};
      r_d_sync <= {r_d_sync[0], ps2_d_in};
      r_filter <= {r_c_sync[1], r_filter[FILTER_LEN-1:1]};
      r_fclk   <= w_fclk_next;
    end
  end

  always_comb begin
    w_fclk_next = r_fclk;
    if (r_filter == '1) begin
      w_fclk_next = 1'b1;
    end else if (r_filter == '0) begin
      w_fclk_next = 1'b0;
    end
  end

  assign fall_tick = r_fclk & ~w_fclk_next;
  assign data_sync = r_d_sync[1];

endmodule

// File: rtl/ps2_receiver.sv
// Device-to-host PS/2 frame receiver: shifts in start, 8 data bits LSB-first,
// odd parity and stop, then reports the byte with parity/stop status flags.
module ps2_receiver
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN = FILTER_LEN_DEF,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF,
  parameter int unsigned TW         = 13
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx_en,
  input  logic                     ps2_c_in,
  input  logic                     ps2_d_in,
  output logic                     rx_idle,
  output logic                     rx_done_tick,
  output logic [PS2_DATA_BITS-1:0] dout,
  output logic                     parity_err,
  output logic                     frame_err,
  output logic                     rx_timeout
);

  rx_state_t                 r_state, w_state_next;
  logic [PS2_FRAME_BITS-1:0] r_b, w_b_next;
  logic [3:0]                r_n, w_n_next;
  logic [TW-1:0]             r_tcnt, w_tcnt_next;
  logic [PS2_DATA_BITS-1:0]  r_dout, w_dout_next;
  logic                      r_perr, w_perr_next;
  logic                      r_ferr, w_ferr_next;
  logic                      w_fall;
  logic                      w_data;
  logic                      w_done;
  logic                      w_timeout;
  logic                      w_unused;

  ps2_clk_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filter (
    .clk      (clk),
    .reset    (reset),
    .ps2_c_in (ps2_c_in),
    .ps2_d_in (ps2_d_in),
    .fall_tick(w_fall),
    .data_sync(w_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_b     <= '0;
      r_n     <= '0;
      r_tcnt  <= '0;
      r_dout  <= '0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_b     <= w_b_next;
      r_n     <= w_n_next;
      r_tcnt  <= w_tcnt_next;
      r_dout  <= w_dout_next;
      r_perr  <= w_perr_next;
      r_ferr  <= w_ferr_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_b_next     = r_b;
    w_n_next     = r_n;
    w_tcnt_next  = r_tcnt;
    w_dout_next  = r_dout;
    w_perr_next  = r_perr;
    w_ferr_next  = r_ferr;
    w_done       = 1'b0;
    w_timeout    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_fall && rx_en && !w_data) begin
          w_b_next     = {w_data, r_b[PS2_FRAME_BITS-1:1]};
          w_n_next     = 4'd9;
          w_tcnt_next  = '0;
          w_state_next = DPS;
        end
      end
      DPS: begin
        // Losing rx_en means the transmitter owns the bus; drop the frame.
        if (!rx_en) begin
          w_state_next = IDLE;
        end else if (w_fall) begin
          w_b_next    = {w_data, r_b[PS2_FRAME_BITS-1:1]};
          w_tcnt_next = '0;
          if (r_n == 4'd0) begin
            w_state_next = LOAD;
          end else begin
            w_n_next = r_n - 4'd1;
          end
        end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
          w_timeout    = 1'b1;
          w_state_next = IDLE;
        end else begin
          w_tcnt_next = r_tcnt + 1'b1;
        end
      end
      LOAD: begin
        w_done       = 1'b1;
        w_dout_next  = r_b[8:1];
        w_perr_next  = ~^r_b[9:1];
        w_ferr_next  = ~r_b[10];
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Start bit is always 0 once a frame is accepted, so it carries no status.
  assign w_unused = r_b[0];

  assign rx_idle      = (r_state == IDLE);
  assign rx_done_tick = w_done;
  assign rx_timeout   = w_timeout;
  assign dout         = r_dout;
  assign parity_err   = r_perr;
  assign frame_err    = r_ferr;

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed plus randomized frame stimulus for ps2_receiver, checked against a
// frame-level reference model of the PS/2 receive rules.
module tb_ps2_receiver;

  localparam int unsigned FL  = 8;
  localparam int unsigned TO  = 5000;
  localparam int unsigned MAX_LAT = FL + 4;
  localparam int unsigned TO_TOL  = FL + 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_en = 1'b1;
  logic       ps2_c_in = 1'b1;
  logic       ps2_d_in = 1'b1;
  logic       rx_idle;
  logic       rx_done_tick;
  logic [7:0] dout;
  logic       parity_err;
  logic       frame_err;
  logic       rx_timeout;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int done_cnt = 0;
  int to_cnt = 0;
  int busy_cnt = 0;
  int done_cyc = 0;
  int to_cyc = 0;
  int last_fall = 0;

  ps2_receiver #(
    .FILTER_LEN(FL),
    .TIMEOUT   (TO),
    .TW        (13)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_en       (rx_en),
    .ps2_c_in    (ps2_c_in),
    .ps2_d_in    (ps2_d_in),
    .rx_idle     (rx_idle),
    .rx_done_tick(rx_done_tick),
    .dout        (dout),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .rx_timeout  (rx_timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rx_done_tick === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (rx_timeout === 1'b1) begin
      to_cnt++;
      to_cyc = cyc;
    end
    if (rx_idle !== 1'b1) busy_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame as transmitted on the wire, index 0 first.
  function automatic logic [10:0] make_frame(input logic [7:0] data, input logic par, input logic stop);
    return {stop, par, data, 1'b0};
  endfunction

  // Device-side bit timing: data changes while clock is high, 400 clk per bit.
  task automatic send_bits(input logic [10:0] bits, input int first, input int count);
    for (int i = first; i < first + count; i++) begin
      ps2_d_in = bits[i];
      wait_cycles(100);
      ps2_c_in = 1'b0;
      last_fall = cyc;
      wait_cycles(200);
      ps2_c_in = 1'b1;
      wait_cycles(100);
    end
    ps2_d_in = 1'b1;
  endtask

  // Reference: byte is bits 1..8, parity ok when data+parity has odd ones,
  // frame ok when the stop bit is 1.
  task automatic run_frame(input string tag, input logic [7:0] data, input logic par, input logic stop);
    logic [10:0] f;
    int d0, t0, lat;
    int ones;
    logic exp_perr;
    f = make_frame(data, par, stop);
    ones = $countones(data) + int'(par);
    exp_perr = (ones % 2 == 1) ? 1'b0 : 1'b1;
    d0 = done_cnt;
    t0 = to_cnt;
    send_bits(f, 0, 11);
    wait_cycles(20);
    lat = done_cyc - last_fall;
    check({tag, "_done"}, done_cnt - d0, 1);
    check({tag, "_dout"}, dout, data);
    check({tag, "_perr"}, parity_err, exp_perr);
    check({tag, "_ferr"}, frame_err, !stop);
    check({tag, "_idle"}, rx_idle, 1'b1);
    check({tag, "_no_to"}, to_cnt - t0, 0);
    check({tag, "_lat"}, (lat >= 1 && lat <= int'(MAX_LAT)), 1'b1);
  endtask

  initial begin
    logic [10:0] f;
    logic [7:0]  rd;
    logic [7:0]  prev;
    int d0, t0, b0, dt;

    // Reset state
    wait_cycles(5);
    check("rst_idle", rx_idle, 1'b1);
    check("rst_dout", dout, 8'h00);
    check("rst_perr", parity_err, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_done", rx_done_tick, 1'b0);
    check("rst_to", rx_timeout, 1'b0);
    reset = 1'b0;
    wait_cycles(20);

    run_frame("a3_ok", 8'hA3, 1'b1, 1'b1);
    run_frame("a3_badpar", 8'hA3, 1'b0, 1'b1);
    run_frame("5a_badstop", 8'h5A, 1'b1, 1'b0);

    // Short low glitch on the clock while idle
    d0 = done_cnt; t0 = to_cnt; b0 = busy_cnt;
    ps2_c_in = 1'b0;
    wait_cycles(3);
    ps2_c_in = 1'b1;
    wait_cycles(50);
    check("glitch_busy", busy_cnt - b0, 0);
    check("glitch_done", done_cnt - d0, 0);
    check("glitch_to", to_cnt - t0, 0);
    check("glitch_idle", rx_idle, 1'b1);
    run_frame("5a_after_glitch", 8'h5A, 1'b1, 1'b1);

    // Timeout after start + 4 data bits
    prev = dout;
    d0 = done_cnt; t0 = to_cnt;
    f = make_frame(8'hC6, 1'b1, 1'b1);
    send_bits(f, 0, 5);
    for (int i = 0; i < int'(TO) + 200 && to_cnt == t0; i++) wait_cycles(1);
    wait_cycles(2);
    dt = to_cyc - last_fall;
    check("to_pulse", to_cnt - t0, 1);
    check("to_window", (dt >= int'(TO - TO_TOL) && dt <= int'(TO + TO_TOL)), 1'b1);
    check("to_no_done", done_cnt - d0, 0);
    check("to_dout_hold", dout, prev);
    check("to_idle", rx_idle, 1'b1);
    run_frame("a3_after_to", 8'hA3, 1'b1, 1'b1);

    // Abort by dropping rx_en after data bit 3; rest of frame sent while disabled
    prev = dout;
    d0 = done_cnt;
    f = make_frame(8'h3C, 1'b1, 1'b1);
    send_bits(f, 0, 4);
    check("en_abort_busy", rx_idle, 1'b0);
    rx_en = 1'b0;
    wait_cycles(2);
    check("en_abort_idle", rx_idle, 1'b1);
    send_bits(f, 4, 7);
    wait_cycles(20);
    rx_en = 1'b1;
    wait_cycles(20);
    check("en_abort_done", done_cnt - d0, 0);
    check("en_abort_dout", dout, prev);

    // Abort by reset after data bit 5; held for the remainder of the frame
    d0 = done_cnt;
    f = make_frame(8'h81, 1'b1, 1'b1);
    send_bits(f, 0, 6);
    check("rst_abort_busy", rx_idle, 1'b0);
    reset = 1'b1;
    #1;
    check("rst_abort_idle", rx_idle, 1'b1);
    check("rst_abort_dout", dout, 8'h00);
    check("rst_abort_perr", parity_err, 1'b0);
    check("rst_abort_ferr", frame_err, 1'b0);
    check("rst_abort_done", rx_done_tick, 1'b0);
    check("rst_abort_to", rx_timeout, 1'b0);
    send_bits(f, 6, 5);
    reset = 1'b0;
    wait_cycles(20);
    check("rst_abort_nodone", done_cnt - d0, 0);
    run_frame("after_rst", 8'h96, 1'b1, 1'b1);

    // Randomized frames with random parity and stop values
    for (int k = 0; k < 4; k++) begin
      logic par, stop;
      rd   = 8'($urandom_range(255, 0));
      par  = 1'($urandom_range(1, 0));
      stop = ($urandom_range(3, 0) != 0);
      run_frame($sformatf("rand%0d", k), rd, par, stop);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
